mips_mc_control: RTL and testbench

//  Multicycle control FSM for the MIPS datapath: sequences PC, instruction memory, register file and ALU per instruction.

---
 rtl/mips_pkg.sv | 44 ++++
 rtl/mips_mc_control_if.sv | 35 +++
 rtl/mips_alu_decoder.sv | 24 ++
 rtl/mips_mc_control.sv | 214 +++++++++++++++++++++
 tb/tb_mips_mc_control.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - FSM states, opcode/funct constants and ALU control codes for the multicycle MIPS control
package mips_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_R_EXEC,
      S_R_WB,
      S_MEM_ADDR,
      S_MEM_READ,
      S_MEM_WB,
      S_MEM_WRITE,
      S_BRANCH,
      S_JUMP,
      S_I_EXEC,
      S_I_WB
`ifdef MIPS_HALT_EN
      , S_HALT
`endif
   } state_t;

   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_SUB = 4'b0110,
      ALU_SLT = 4'b0111
   } alu_ctrl_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   localparam logic [5:0] F_ADD = 6'h20;
   localparam logic [5:0] F_SUB = 6'h22;
   localparam logic [5:0] F_AND = 6'h24;
   localparam logic [5:0] F_OR  = 6'h25;
   localparam logic [5:0] F_SLT = 6'h2A;

endpackage

// File: rtl/mips_mc_control_if.sv
// rtl/mips_mc_control_if.sv - control <-> datapath signal bundle (master = control FSM, slave = datapath)
interface mips_mc_control_if #(parameter int CNT_W = 32);
   logic [5:0]       opcode;
   logic [5:0]       funct;
   logic             zero;
   logic             pc_en;
   logic             i_or_d;
   logic             mem_read;
   logic             mem_write;
   logic             ir_write;
   logic             reg_dst;
   logic             mem_to_reg;
   logic             reg_write;
   logic             alu_src_a;
   logic [1:0]       alu_src_b;
   logic [3:0]       alu_ctrl;
   logic [1:0]       pc_src;
   logic             illegal;
   logic             halted;
   logic [CNT_W-1:0] instr_count;

   modport master (
      input  opcode, funct, zero,
      output pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
             reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_src, illegal, halted,
             instr_count
   );

   modport slave (
      output opcode, funct, zero,
      input  pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
             reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_src, illegal, halted,
             instr_count
   );
endinterface

// File: rtl/mips_alu_decoder.sv
// rtl/mips_alu_decoder.sv - R-type funct field to ALU control code, flags unsupported funct values
module mips_alu_decoder
   import mips_pkg::*;
(
   input  logic [5:0] funct,
   output alu_ctrl_t  alu_ctrl,
   output logic       funct_valid
);

   // Pure lookup; unsupported funct falls back to add and is reported invalid
   always_comb begin
      alu_ctrl    = ALU_ADD;
      funct_valid = 1'b1;
      case (funct)
         F_ADD:   alu_ctrl = ALU_ADD;
         F_SUB:   alu_ctrl = ALU_SUB;
         F_AND:   alu_ctrl = ALU_AND;
         F_OR:    alu_ctrl = ALU_OR;
         F_SLT:   alu_ctrl = ALU_SLT;
         default: funct_valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/mips_mc_control.sv
// rtl/mips_mc_control.sv - multicycle MIPS control FSM with retired-instruction counter; optional HALT via MIPS_HALT_EN
module mips_mc_control
   import mips_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   mips_mc_control_if.master   bus
);

   state_t           state;
   state_t           next_state;
   logic             illegal_q;
   logic             illegal_d;
   logic             retire;
   logic [CNT_W-1:0] count;

   logic             pc_write;
   logic             branch;
   logic             i_or_d;
   logic             mem_read;
   logic             mem_write;
   logic             ir_write;
   logic             reg_dst;
   logic             mem_to_reg;
   logic             reg_write;
   logic             alu_src_a;
   logic [1:0]       alu_src_b;
   logic [3:0]       alu_ctrl;
   logic [1:0]       pc_src;
   logic             halt_now;

   alu_ctrl_t        r_alu_ctrl;
   logic             funct_valid;

   mips_alu_decoder u_alu_dec (
      .funct       (bus.funct),
      .alu_ctrl    (r_alu_ctrl),
      .funct_valid (funct_valid)
   );

   // State register, one-cycle illegal flag and retire counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_FETCH;
         illegal_q <= 1'b0;
         count     <= '0;
      end else begin
         state     <= next_state;
         illegal_q <= illegal_d;
         if (retire)
            count <= count + CNT_W'(1);
      end
   end

   // Next-state logic and Moore decode of the datapath controls
   always_comb begin
      next_state = state;
      illegal_d  = 1'b0;
      retire     = 1'b0;
      pc_write   = 1'b0;
      branch     = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_ctrl   = 4'b0000;
      pc_src     = 2'b00;
      halt_now   = 1'b0;
      case (state)
         S_FETCH: begin
            mem_read   = 1'b1;
            ir_write   = 1'b1;
            alu_src_b  = 2'b01;
            alu_ctrl   = ALU_ADD;
            pc_write   = 1'b1;
            next_state = S_DECODE;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            alu_ctrl  = ALU_ADD;
            case (bus.opcode)
               OP_RTYPE:      next_state = S_R_EXEC;
               OP_LW, OP_SW:  next_state = S_MEM_ADDR;
               OP_BEQ:        next_state = S_BRANCH;
               OP_J:          next_state = S_JUMP;
               OP_ADDI:       next_state = S_I_EXEC;
`ifdef MIPS_HALT_EN
               OP_HALT:       next_state = S_HALT;
`endif
               default: begin
                  next_state = S_FETCH;
                  illegal_d  = 1'b1;
               end
            endcase
         end
         S_R_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b00;
            alu_ctrl  = r_alu_ctrl;
            if (funct_valid) begin
               next_state = S_R_WB;
            end else begin
               next_state = S_FETCH;
               illegal_d  = 1'b1;
            end
         end
         S_R_WB: begin
            reg_write  = 1'b1;
            reg_dst    = 1'b1;
            retire     = 1'b1;
            next_state = S_FETCH;
         end
         S_MEM_ADDR: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            alu_ctrl   = ALU_ADD;
            next_state = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         end
         S_MEM_READ: begin
            mem_read   = 1'b1;
            i_or_d     = 1'b1;
            next_state = S_MEM_WB;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            retire     = 1'b1;
            next_state = S_FETCH;
         end
         S_MEM_WRITE: begin
            mem_write  = 1'b1;
            i_or_d     = 1'b1;
            retire     = 1'b1;
            next_state = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b00;
            alu_ctrl   = ALU_SUB;
            pc_src     = 2'b01;
            branch     = 1'b1;
            retire     = 1'b1;
            next_state = S_FETCH;
         end
         S_JUMP: begin
            pc_src     = 2'b10;
            pc_write   = 1'b1;
            retire     = 1'b1;
            next_state = S_FETCH;
         end
         S_I_EXEC: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            alu_ctrl   = ALU_ADD;
            next_state = S_I_WB;
         end
         S_I_WB: begin
            reg_write  = 1'b1;
            retire     = 1'b1;
            next_state = S_FETCH;
         end
`ifdef MIPS_HALT_EN
         S_HALT: begin
            halt_now   = 1'b1;
            next_state = S_HALT;
         end
`endif
         default: next_state = S_FETCH;
      endcase
   end

   // Drive the bus; reset suppresses every strobe so an aborted instruction leaves no side effect
   always_comb begin
      bus.pc_en       = 1'b0;
      bus.i_or_d      = 1'b0;
      bus.mem_read    = 1'b0;
      bus.mem_write   = 1'b0;
      bus.ir_write    = 1'b0;
      bus.reg_dst     = 1'b0;
      bus.mem_to_reg  = 1'b0;
      bus.reg_write   = 1'b0;
      bus.alu_src_a   = 1'b0;
      bus.alu_src_b   = 2'b00;
      bus.alu_ctrl    = 4'b0000;
      bus.pc_src      = 2'b00;
      bus.illegal     = 1'b0;
      bus.halted      = 1'b0;
      bus.instr_count = count;
      if (!rst) begin
         bus.pc_en      = pc_write | (branch & bus.zero);
         bus.i_or_d     = i_or_d;
         bus.mem_read   = mem_read;
         bus.mem_write  = mem_write;
         bus.ir_write   = ir_write;
         bus.reg_dst    = reg_dst;
         bus.mem_to_reg = mem_to_reg;
         bus.reg_write  = reg_write;
         bus.alu_src_a  = alu_src_a;
         bus.alu_src_b  = alu_src_b;
         bus.alu_ctrl   = alu_ctrl;
         bus.pc_src     = pc_src;
         bus.illegal    = illegal_q;
         bus.halted     = halt_now;
      end
   end

endmodule

// File: tb/tb_mips_mc_control.sv
// tb/tb_mips_mc_control.sv - directed plus randomized check of mips_mc_control against a per-instruction cycle-table model
module tb_mips_mc_control;

   typedef struct packed {
      logic       pc_en;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [3:0] alu_ctrl;
      logic [1:0] pc_src;
      logic       illegal;
      logic       halted;
   } ctl_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          errors = 0;
   int          checks = 0;
   logic        pend_illegal = 1'b0;
   logic [31:0] exp_count = '0;

   mips_mc_control_if #(.CNT_W(32)) bus ();

   mips_mc_control #(.CNT_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   function automatic ctl_t observe();
      ctl_t o;
      o.pc_en      = bus.pc_en;
      o.i_or_d     = bus.i_or_d;
      o.mem_read   = bus.mem_read;
      o.mem_write  = bus.mem_write;
      o.ir_write   = bus.ir_write;
      o.reg_dst    = bus.reg_dst;
      o.mem_to_reg = bus.mem_to_reg;
      o.reg_write  = bus.reg_write;
      o.alu_src_a  = bus.alu_src_a;
      o.alu_src_b  = bus.alu_src_b;
      o.alu_ctrl   = bus.alu_ctrl;
      o.pc_src     = bus.pc_src;
      o.illegal    = bus.illegal;
      o.halted     = bus.halted;
      return o;
   endfunction

   // Control word helper: one call per datapath step described by the instruction's meaning
   function automatic ctl_t word(input logic [1:0] src_b, input logic [3:0] alu, input logic src_a);
      ctl_t w = '0;
      w.alu_src_b = src_b;
      w.alu_ctrl  = alu;
      w.alu_src_a = src_a;
      return w;
   endfunction

   function automatic logic funct_ok(input logic [5:0] f);
      return (f == 6'h20) || (f == 6'h22) || (f == 6'h24) || (f == 6'h25) || (f == 6'h2A);
   endfunction

   function automatic logic [3:0] funct_alu(input logic [5:0] f);
      case (f)
         6'h22:   return 4'b0110;
         6'h24:   return 4'b0000;
         6'h25:   return 4'b0001;
         6'h2A:   return 4'b0111;
         default: return 4'b0010;
      endcase
   endfunction

   task automatic chk(input string tag, input ctl_t obs, input ctl_t expv, input ctl_t mask);
      checks++;
      assert ((obs & mask) === (expv & mask)) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic chk_count(input string tag);
      checks++;
      assert (bus.instr_count === exp_count) else begin
         errors++;
         $error("FAIL %s instr_count observed=%0d expected=%0d", tag, bus.instr_count, exp_count);
      end
   endtask

   // Builds the expected per-cycle control words of one instruction and checks them.
   // Entry: just after the posedge that begins the instruction's fetch cycle.
   task automatic exec(input string tag, input logic [5:0] op, input logic [5:0] fn, input logic z);
      ctl_t q[$];
      ctl_t m[$];
      ctl_t w;
      logic legal = 1'b1;
      bus.opcode = op;
      bus.funct  = fn;
      bus.zero   = z;
      w = word(2'b01, 4'b0010, 1'b0);
      w.mem_read = 1'b1; w.ir_write = 1'b1; w.pc_en = 1'b1; w.illegal = pend_illegal;
      q.push_back(w); m.push_back('1);
      pend_illegal = 1'b0;
      q.push_back(word(2'b11, 4'b0010, 1'b0)); m.push_back('1);
      case (op)
         6'b000000: begin
            w = word(2'b00, funct_alu(fn), 1'b1);
            q.push_back(w);
            w = '1;
            if (!funct_ok(fn)) w.alu_ctrl = 4'b0000;
            m.push_back(w);
            if (funct_ok(fn)) begin
               w = '0; w.reg_write = 1'b1; w.reg_dst = 1'b1;
               q.push_back(w); m.push_back('1);
            end else begin
               legal = 1'b0;
               pend_illegal = 1'b1;
            end
         end
         6'b100011, 6'b101011: begin
            q.push_back(word(2'b10, 4'b0010, 1'b1)); m.push_back('1);
            w = '0; w.i_or_d = 1'b1;
            if (op == 6'b100011) begin
               w.mem_read = 1'b1;
               q.push_back(w); m.push_back('1);
               w = '0; w.reg_write = 1'b1; w.mem_to_reg = 1'b1;
            end else begin
               w.mem_write = 1'b1;
            end
            q.push_back(w); m.push_back('1);
         end
         6'b000100: begin
            w = word(2'b00, 4'b0110, 1'b1);
            w.pc_src = 2'b01; w.pc_en = z;
            q.push_back(w); m.push_back('1);
         end
         6'b000010: begin
            w = '0; w.pc_src = 2'b10; w.pc_en = 1'b1;
            q.push_back(w); m.push_back('1);
         end
         6'b001000: begin
            q.push_back(word(2'b10, 4'b0010, 1'b1)); m.push_back('1);
            w = '0; w.reg_write = 1'b1;
            q.push_back(w); m.push_back('1);
         end
         default: begin
            legal = 1'b0;
            pend_illegal = 1'b1;
         end
      endcase
      for (int k = 0; k < q.size(); k++) begin
         @(negedge clk);
         chk($sformatf("%s_c%0d", tag, k + 1), observe(), q[k], m[k]);
      end
      @(posedge clk);
      #1;
      if (legal) exp_count = exp_count + 32'd1;
      chk_count({tag, "_count"});
   endtask

   initial begin
      ctl_t zw;
      ctl_t hw;
      logic [5:0] rop;
      logic [5:0] rfn;
      logic [5:0] ops[6];
      logic [5:0] fns[5];
      zw = '0;
      ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
      ops[3] = 6'b000100; ops[4] = 6'b000010; ops[5] = 6'b001000;
      fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2A;
      bus.opcode = '0;
      bus.funct  = '0;
      bus.zero   = 1'b0;

      // reset: held two cycles, every control quiet, counter cleared
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", observe(), zw, '1);
      chk_count("reset_count");
      @(posedge clk);
      #1 rst = 1'b0;

      // directed instruction mix
      exec("add", 6'b000000, 6'h20, 1'b0);
      exec("beq_taken", 6'b000100, 6'h00, 1'b1);
      exec("beq_not_taken", 6'b000100, 6'h00, 1'b0);
      exec("lw", 6'b100011, 6'h00, 1'b0);
      exec("sw", 6'b101011, 6'h00, 1'b0);
      exec("j", 6'b000010, 6'h00, 1'b0);
      exec("addi", 6'b001000, 6'h00, 1'b0);
      exec("slt", 6'b000000, 6'h2A, 1'b0);
      exec("bad_funct", 6'b000000, 6'h3F, 1'b0);
      exec("after_bad_funct", 6'b000000, 6'h22, 1'b0);

`ifdef MIPS_HALT_EN
      // halt: decode enters a parked state that only reset leaves
      exec("pre_halt", 6'b000010, 6'h00, 1'b0);
      bus.opcode = 6'b111111;
      @(negedge clk);
      @(negedge clk);
      hw = '0; hw.halted = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk($sformatf("halt_c%0d", k + 3), observe(), hw, '1);
      end
      chk_count("halt_count");
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      exp_count = '0;
      chk("halt_cleared", observe(), zw, 32'h1);
`else
      hw = '0;
      exec("op_3f_illegal", 6'b111111, 6'h00, 1'b0);
      exec("after_op_3f", 6'b001000, 6'h00, 1'b0);
`endif

      // reset during MEM_READ of lw: no writeback, restart at fetch, counter cleared
      bus.opcode = 6'b100011;
      bus.funct  = 6'h00;
      repeat (4) @(negedge clk);
      hw = '0; hw.mem_read = 1'b1; hw.i_or_d = 1'b1;
      chk("abort_mem_read", observe(), hw, '1);
      rst = 1'b1;
      #1;
      chk("abort_rst_cycle", observe(), zw, '1);
      @(posedge clk);
      #1 rst = 1'b0;
      exp_count = '0;
      chk_count("abort_count");
      exec("after_abort", 6'b000000, 6'h25, 1'b0);

      // randomized instruction stream
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 7))
            6: begin
               rop = 6'b000000;
               rfn = 6'($urandom_range(0, 63));
            end
            7: begin
               rop = 6'($urandom_range(0, 62));
               rfn = fns[$urandom_range(0, 4)];
            end
            default: begin
               rop = ops[$urandom_range(0, 5)];
               rfn = fns[$urandom_range(0, 4)];
            end
         endcase
         exec($sformatf("rnd%0d_op%02h", i, rop), rop, rfn, 1'($urandom_range(0, 1)));
      end
      exec("final", 6'b000010, 6'h00, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
